mux_in_seq: RTL and testbench

- Parametrised, registered successor to the filter operand multiplexer in the FILTRO datapath.
- Selects one of N_IN signed operands onto the MAC input bus.
- Manual mode: the index is driven externally.
- Auto mode: after a start pulse, the block sequences all operands in order, with a valid/ready handshake towards the MAC and a done pulse at the end of the sequence.

---
 rtl/mux_in_seq.sv | 95 +++++++++
 tb/tb_mux_in_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_in_seq.sv
// Registered operand multiplexer for the FILTRO MAC input bus.
// Manual mode picks a slot by index; auto mode streams every slot with a valid/ready handshake.
module mux_in_seq #(
   parameter int unsigned cant_bits = 25,
   parameter int unsigned N_IN      = 6,
   parameter int unsigned SEL_W     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_IN*cant_bits-1:0]   in_bus,
   input  logic                        modo,
   input  logic [SEL_W-1:0]            selec,
   input  logic                        start,
   input  logic                        ready,
   output logic signed [cant_bits-1:0] in,
   output logic                        valid,
   output logic [SEL_W-1:0]            idx,
   output logic                        busy,
   output logic                        done
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               r_state;
   logic [cant_bits-1:0] w_man_data;
   logic [cant_bits-1:0] w_next_data;
   logic [cant_bits-1:0] w_first_data;
   logic [SEL_W-1:0]     w_idx_inc;
   logic                 w_man_legal;

   // Explicit compare-and-select keeps index widths independent of N_IN.
   function automatic logic [cant_bits-1:0] slot_at(input logic [SEL_W-1:0] s,
                                                   input logic [N_IN*cant_bits-1:0] bus);
      logic [cant_bits-1:0] v;
      v = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (s == SEL_W'(k)) v = bus[k*cant_bits +: cant_bits];
      end
      return v;
   endfunction

   always_comb begin
      w_idx_inc    = idx + SEL_W'(1);
      w_man_legal  = 32'(selec) < N_IN;
      w_man_data   = slot_at(selec, in_bus);
      w_next_data  = slot_at(w_idx_inc, in_bus);
      w_first_data = in_bus[cant_bits-1:0];
   end

   // Single-process FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         in      <= '0;
         valid   <= 1'b0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (r_state == IDLE) begin
            busy <= 1'b0;
            if (!modo) begin
               idx   <= selec;
               valid <= w_man_legal;
               in    <= w_man_legal ? w_man_data : '0;
            end else if (start) begin
               r_state <= RUN;
               busy    <= 1'b1;
               idx     <= '0;
               in      <= w_first_data;
               valid   <= 1'b1;
            end else begin
               valid <= 1'b0;
            end
         end else begin
            // Without a handshake everything holds and in_bus is not resampled.
            if (ready) begin
               if (idx == LAST_IDX) begin
                  r_state <= IDLE;
                  valid   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  idx <= w_idx_inc;
                  in  <= w_next_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_in_seq.sv
// Scoreboard bench for mux_in_seq: stimulus queues expected auto beats and done pulses,
// a negedge monitor pops them on each handshake / done.
module tb_mux_in_seq;

   localparam int unsigned CB = 25;
   localparam int unsigned N  = 6;
   localparam int unsigned SW = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N*CB-1:0]       in_bus;
   logic                  modo;
   logic [SW-1:0]         selec;
   logic                  start;
   logic                  ready;
   logic signed [CB-1:0]  in;
   logic                  valid;
   logic [SW-1:0]         idx;
   logic                  busy;
   logic                  done;

   logic signed [CB-1:0]  slot [N];

   typedef struct {
      bit                   is_done;
      logic signed [CB-1:0] data;
      logic [SW-1:0]        idx;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   pattern [N] = '{10, -3, 7, -25, 100, -1};

   for (genvar g = 0; g < N; g++) begin : g_bus
      assign in_bus[g*CB +: CB] = slot[g];
   end

   mux_in_seq #(.cant_bits(CB), .N_IN(N), .SEL_W(SW)) dut (
      .clk(clk), .reset(reset), .in_bus(in_bus), .modo(modo), .selec(selec),
      .start(start), .ready(ready), .in(in), .valid(valid), .idx(idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input int act, input int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int d, input int i);
      q.push_back('{is_done: 1'b0, data: CB'(d), idx: SW'(i)});
   endtask

   task automatic push_done();
      q.push_back('{is_done: 1'b1, data: '0, idx: '0});
   endtask

   task automatic push_full_seq();
      for (int i = 0; i < N; i++) push_beat(pattern[i], i);
      push_done();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in"},    in,    0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_idx"},   idx,   0);
      chk({tag, "_busy"},  busy,  0);
      chk({tag, "_done"},  done,  0);
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_finished_in_budget"}, busy, 0);
   endtask

   // Monitor: done pulses and auto handshakes must match the queue head, in order.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0 || !q[0].is_done) chk("unexpected_done", 1, 0);
         else begin
            m_e = q.pop_front();
            chk("done_pulse", done, 1);
         end
      end
      if (valid === 1'b1 && ready === 1'b1 && busy === 1'b1) begin
         if (q.size() == 0 || q[0].is_done) chk("unexpected_beat_idx", idx, -1);
         else begin
            m_e = q.pop_front();
            chk("beat_in",  in,  m_e.data);
            chk("beat_idx", idx, m_e.idx);
         end
      end
   end

   initial begin
      // Reset with random inputs
      reset = 1'b0;
      repeat (3) begin
         for (int k = 0; k < N; k++) slot[k] = CB'($urandom);
         modo  = 1'($urandom);
         selec = SW'($urandom);
         start = 1'($urandom);
         ready = 1'($urandom);
         tick();
      end
      chk_zero("reset");

      // Manual mode
      for (int k = 0; k < N; k++) slot[k] = CB'(pattern[k]);
      reset = 1'b1;
      modo  = 1'b0;
      selec = 4'd3;
      start = 1'b0;
      ready = 1'b1;
      tick();
      chk("man3_in",    in,    -25);
      chk("man3_valid", valid, 1);
      chk("man3_idx",   idx,   3);
      chk("man3_busy",  busy,  0);
      selec = 4'd9;
      tick();
      chk("man9_in",    in,    0);
      chk("man9_valid", valid, 0);
      chk("man9_idx",   idx,   9);

      // Auto mode, ready always high
      modo  = 1'b1;
      selec = 4'd0;
      push_full_seq();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         chk("auto_valid", valid, 1);
         chk("auto_busy",  busy,  1);
         chk("auto_idx",   idx,   i);
         tick();
      end
      chk("auto_end_done",  done,  1);
      chk("auto_end_valid", valid, 0);
      chk("auto_end_busy",  busy,  0);
      chk("auto_end_idx",   idx,   5);
      chk("auto_end_in",    in,    -1);
      tick();
      chk("auto_done_once", done,  0);

      // Backpressure at idx 2; slot 3 changes during the stall
      push_beat(10, 0);
      push_beat(-3, 1);
      push_beat(7, 2);
      push_beat(55, 3);
      push_beat(100, 4);
      push_beat(-1, 5);
      push_done();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("bp_at_idx2", idx, 2);
      ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         tick();
         chk("bp_hold_in",    in,    7);
         chk("bp_hold_idx",   idx,   2);
         chk("bp_hold_valid", valid, 1);
         if (s == 1) slot[3] = -25'sd8;
      end
      slot[3] = 25'sd55;
      ready = 1'b1;
      run_until_idle("bp", 20);
      chk("bp_done", done, 1);
      slot[3] = -25'sd25;
      tick();

      // start re-pulsed and modo dropped mid-run are ignored
      push_full_seq();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      start = 1'b1;
      tick();
      chk("ign_idx4",  idx,  4);
      chk("ign_busy4", busy, 1);
      start = 1'b0;
      modo  = 1'b0;
      tick();
      chk("ign_idx5",  idx,  5);
      chk("ign_busy5", busy, 1);
      tick();
      chk("ign_done",  done, 1);
      chk("ign_idle",  busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("man_start_busy",  busy,  0);
      chk("man_start_valid", valid, 1);
      chk("man_start_idx",   idx,   0);
      chk("man_start_in",    in,    10);

      // Abort with reset at beat 4, then a fresh full sequence
      modo = 1'b1;
      for (int i = 0; i < 4; i++) push_beat(pattern[i], i);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("abort_at_idx4", idx, 4);
      reset = 1'b0;
      ready = 1'b0;
      tick();
      chk_zero("abort");
      reset = 1'b1;
      ready = 1'b1;
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_idle",    busy, 0);
      push_full_seq();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_until_idle("fresh", 20);
      chk("fresh_done", done, 1);

      tick();
      tick();
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
